alu_operand_sequencer: RTL and testbench



---
 rtl/alu_operand_sequencer_if.sv | 28 ++
 rtl/alu_operand_sequencer.sv | 113 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Pin-side and ALU-side signal bundle for the byte-serial ALU operand sequencer.
// slave = sequencer view; master = pins plus ALU view.
interface alu_operand_sequencer_if;
  logic [7:0] data_in;
  logic       strobe;
  logic       abort;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] res_out;
  logic       res_carry;
  logic       res_zero;
  logic       res_valid;
  logic       busy;
  logic       err;

  modport slave (
    input  data_in, strobe, abort, alu_result, alu_carry,
    output alu_a, alu_b, alu_sel, res_out, res_carry, res_zero, res_valid, busy, err
  );

  modport master (
    output data_in, strobe, abort, alu_result, alu_carry,
    input  alu_a, alu_b, alu_sel, res_out, res_carry, res_zero, res_valid, busy, err
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Loads A, B, opcode one byte per async strobe edge, runs the ALU, captures result/flags.
// Latency: result valid 2 edges after the opcode ld pulse; no backpressure, ld in S_EX is dropped.
module alu_operand_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                     clk,
  input logic                     rst_n,
  alu_operand_sequencer_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_A, S_B, S_OP, S_EX} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   ld_q;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [7:0]             alu_a_q;
  logic [7:0]             alu_b_q;
  logic [2:0]             alu_sel_q;
  logic [7:0]             res_out_q;
  logic                   res_carry_q;
  logic                   res_zero_q;
  logic                   res_valid_q;
  logic                   err_q;
  logic                   loading;
  logic                   timeout;

  // Edge flop resets low so a strobe already high at reset release yields one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      ld_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.strobe};
      edge_q <= sync_q[SYNC_STAGES-1];
      ld_q   <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  assign loading = (state_q == S_B) || (state_q == S_OP);
  assign timeout = loading && !ld_q && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.abort || timeout || ld_q || !loading) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Priority: abort, then timeout, then ld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_out_q   <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.abort) begin
      state_q     <= S_A;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (timeout) begin
      state_q <= S_A;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        S_A: if (ld_q) begin
          alu_a_q     <= bus.data_in;
          res_valid_q <= 1'b0;
          err_q       <= 1'b0;
          state_q     <= S_B;
        end
        S_B: if (ld_q) begin
          alu_b_q <= bus.data_in;
          state_q <= S_OP;
        end
        S_OP: if (ld_q) begin
          alu_sel_q <= bus.data_in[2:0];
          state_q   <= S_EX;
        end
        S_EX: begin
          res_out_q   <= bus.alu_result;
          res_carry_q <= bus.alu_carry;
          res_zero_q  <= (bus.alu_result == 8'h00);
          res_valid_q <= 1'b1;
          state_q     <= S_A;
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_A);
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small behavioural ALU on the alu_* side.
module tb_alu_operand_sequencer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_operand_sequencer_if bus ();

  alu_operand_sequencer #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Add and two's-complement subtract, carry is the adder carry-out.
  always_comb begin
    bus.alu_result = 8'h00;
    bus.alu_carry  = 1'b0;
    case (bus.alu_sel)
      3'b000: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.data_in = b;
    bus.strobe  = 1'b1;
    repeat (6) @(negedge clk);
    bus.strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n       = 1'b0;
    bus.data_in = 8'h00;
    bus.strobe  = 1'b0;
    bus.abort   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_alu_a", bus.alu_a, 8'h00);
    chk("rst_res_out", bus.res_out, 8'h00);
    chk("rst_res_valid", {7'd0, bus.res_valid}, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_err", {7'd0, bus.err}, 8'h00);

    // 1: 0x7F + 0x01, with exact capture latency on the opcode byte
    send_byte(8'h7F);
    chk("t1_alu_a", bus.alu_a, 8'h7F);
    chk("t1_busy_after_a", {7'd0, bus.busy}, 8'h01);
    send_byte(8'h01);
    chk("t1_alu_b", bus.alu_b, 8'h01);
    @(negedge clk);
    bus.data_in = 8'h00;
    bus.strobe  = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("t1_valid_early", {7'd0, bus.res_valid}, 8'h00);
    @(posedge clk);
    #1 chk("t1_valid_on_time", {7'd0, bus.res_valid}, 8'h01);
    @(negedge clk);
    bus.strobe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_res_out", bus.res_out, 8'h80);
    chk("t1_res_carry", {7'd0, bus.res_carry}, 8'h00);
    chk("t1_res_zero", {7'd0, bus.res_zero}, 8'h00);
    chk("t1_busy", {7'd0, bus.busy}, 8'h00);

    // 2: 0xFF + 0x01 wraps to zero with carry
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("t2_res_out", bus.res_out, 8'h00);
    chk("t2_res_carry", {7'd0, bus.res_carry}, 8'h01);
    chk("t2_res_zero", {7'd0, bus.res_zero}, 8'h01);
    chk("t2_res_valid", {7'd0, bus.res_valid}, 8'h01);

    // 3: 5 - 7; next A load drops res_valid but keeps the old result
    send_byte(8'h05);
    chk("t2_valid_cleared", {7'd0, bus.res_valid}, 8'h00);
    chk("t2_res_held", bus.res_out, 8'h00);
    send_byte(8'h07);
    send_byte(8'h01);
    chk("t3_res_out", bus.res_out, 8'hFE);
    chk("t3_res_carry", {7'd0, bus.res_carry}, 8'h00);
    send_byte(8'h05);
    send_byte(8'h07);
    send_byte(8'hF9);
    chk("t3_sel_masked", {5'd0, bus.alu_sel}, 8'h01);
    chk("t3_res_out_f9", bus.res_out, 8'hFE);

    // 4: A only, timeout 16 cycles after the ld is taken
    @(negedge clk);
    bus.data_in = 8'hAA;
    bus.strobe  = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    chk("t4_err_early", {7'd0, bus.err}, 8'h00);
    chk("t4_busy_early", {7'd0, bus.busy}, 8'h01);
    @(posedge clk);
    #1;
    chk("t4_err_set", {7'd0, bus.err}, 8'h01);
    chk("t4_busy_clear", {7'd0, bus.busy}, 8'h00);
    chk("t4_alu_a_kept", bus.alu_a, 8'hAA);
    @(negedge clk);
    bus.strobe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_err_sticky", {7'd0, bus.err}, 8'h01);
    send_byte(8'h02);
    chk("t4_err_cleared", {7'd0, bus.err}, 8'h00);
    send_byte(8'h03);
    send_byte(8'h00);
    chk("t4_res_out", bus.res_out, 8'h05);

    // 5: abort in S_B
    send_byte(8'h11);
    chk("t5_busy_in_b", {7'd0, bus.busy}, 8'h01);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_busy", {7'd0, bus.busy}, 8'h00);
    chk("t5_res_valid", {7'd0, bus.res_valid}, 8'h00);
    chk("t5_err", {7'd0, bus.err}, 8'h00);
    chk("t5_alu_a_kept", bus.alu_a, 8'h11);
    chk("t5_res_out_kept", bus.res_out, 8'h05);
    send_byte(8'h09);
    chk("t5_new_a", bus.alu_a, 8'h09);
    send_byte(8'h04);
    send_byte(8'h00);
    chk("t5_res_out", bus.res_out, 8'h0D);

    // 6: async reset during S_OP, strobe held high across release
    send_byte(8'h33);
    send_byte(8'h44);
    chk("t6_busy_in_op", {7'd0, bus.busy}, 8'h01);
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    bus.data_in = 8'h42;
    bus.strobe  = 1'b1;
    #1;
    chk("t6_async_alu_a", bus.alu_a, 8'h00);
    chk("t6_async_alu_b", bus.alu_b, 8'h00);
    chk("t6_async_res_out", bus.res_out, 8'h00);
    chk("t6_async_busy", {7'd0, bus.busy}, 8'h00);
    chk("t6_async_valid", {7'd0, bus.res_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_a_loaded", bus.alu_a, 8'h42);
    chk("t6_busy_after", {7'd0, bus.busy}, 8'h01);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_single_ld_b", bus.alu_b, 8'h00);
    chk("t6_still_in_b", {7'd0, bus.busy}, 8'h01);
    @(negedge clk);
    bus.strobe = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
